// File: rtl/malu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : malu_pkg
//  Description : Shared types and constants for the multicycle ALU: operation
//                codes, FSM states and carryFlag bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package malu_pkg;

  // Operation codes carried on the 4-bit operation bus; 1011-1111 are illegal.
  typedef enum logic [3:0] {
    OP_PASSB  = 4'b0000,
    OP_ADDSUB = 4'b0001,
    OP_MUL    = 4'b0010,
    OP_DIV    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_NOR    = 4'b0110,
    OP_SRL    = 4'b0111,
    OP_SLL    = 4'b1000,
    OP_SRA    = 4'b1001,
    OP_LUI    = 4'b1010
  } op_e;

  // Sequencer states for the iterative multiply/divide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Bit positions inside carryFlag.
  localparam int FLG_V = 0;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 3;

endpackage
`default_nettype wire

// File: rtl/malu_if.sv
`default_nettype none
// ============================================================================
//  Module      : malu_if
//  Description : Request/result bundle between the EX-stage control and the
//                multicycle ALU. master drives requests, slave is the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface malu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       operation;
  logic [1:0]       sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] outHI;
  logic [WIDTH-1:0] outLO;
  logic [3:0]       carryFlag;
  logic             div0;
  logic             busy;
  logic             done;

  modport master (
    output start, operation, sign, A, B,
    input  Y, outHI, outLO, carryFlag, div0, busy, done
  );

  modport slave (
    input  start, operation, sign, A, B,
    output Y, outHI, outLO, carryFlag, div0, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/malu_muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : malu_muldiv_core
//  Description : Iterative shift-add multiplier and restoring divider working
//                on operand magnitudes, with sign fix-up of the results.
//                Option macro MALU_EARLY_OUT_EN: finish a multiply as soon as
//                the remaining multiplier magnitude reaches zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module malu_muldiv_core
  import malu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             loadDiv,
  input  logic             loadSigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             step,
  output logic             lastIter,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;      // mul: product; div: remainder in low half
  logic [2*WIDTH-1:0] r_mcand;    // mul: shifted multiplicand; div: divisor
  logic [WIDTH-1:0]   r_mplr;     // mul: remaining multiplier; div: dividend/quotient
  logic               r_isDiv;
  logic               r_negLo;    // negate product (mul) or quotient (div)
  logic               r_negHi;    // negate remainder (div)

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_accNext;
  logic [2*WIDTH-1:0] w_mcandNext;
  logic [WIDTH-1:0]   w_mplrNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_remRaw;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot;

  // Signed operations iterate on magnitudes; the MIN magnitude is still exact unsigned.
  assign w_magA = (loadSigned && opA[WIDTH-1]) ? -opA : opA;
  assign w_magB = (loadSigned && opB[WIDTH-1]) ? -opB : opB;

  // One multiply or divide iteration computed from the current register contents.
  always_comb begin
    w_accNext   = r_acc;
    w_mcandNext = r_mcand;
    w_mplrNext  = r_mplr;
    w_remShift  = {r_acc[WIDTH-1:0], r_mplr[WIDTH-1]};
    w_trial     = w_remShift - {1'b0, r_mcand[WIDTH-1:0]};
    if (r_isDiv) begin
      // Trial subtraction borrows (bit WIDTH set) exactly when the divisor does not fit.
      w_accNext  = {{WIDTH{1'b0}}, (w_trial[WIDTH] ? w_remShift[WIDTH-1:0] : w_trial[WIDTH-1:0])};
      w_mplrNext = {r_mplr[WIDTH-2:0], ~w_trial[WIDTH]};
    end else begin
      if (r_mplr[0]) begin
        w_accNext = r_acc + r_mcand;
      end
      w_mcandNext = {r_mcand[2*WIDTH-2:0], 1'b0};
      w_mplrNext  = {1'b0, r_mplr[WIDTH-1:1]};
    end
  end

`ifdef MALU_EARLY_OUT_EN
  assign lastIter = (r_count == CW'(WIDTH - 1)) || (!r_isDiv && (w_mplrNext == '0));
`else
  assign lastIter = (r_count == CW'(WIDTH - 1));
`endif

  // Operand capture on acceptance, then one iteration per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_isDiv <= 1'b0;
      r_negLo <= 1'b0;
      r_negHi <= 1'b0;
    end else if (load) begin
      r_count <= '0;
      r_acc   <= '0;
      r_isDiv <= loadDiv;
      r_negLo <= loadSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
      r_negHi <= loadSigned & loadDiv & opA[WIDTH-1];
      if (loadDiv) begin
        r_mcand <= {{WIDTH{1'b0}}, w_magB};
        r_mplr  <= w_magA;
      end else begin
        r_mcand <= {{WIDTH{1'b0}}, w_magA};
        r_mplr  <= w_magB;
      end
    end else if (step) begin
      r_count <= r_count + CW'(1);
      r_acc   <= w_accNext;
      r_mcand <= w_mcandNext;
      r_mplr  <= w_mplrNext;
    end
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  assign w_prod   = r_negLo ? -r_acc : r_acc;
  assign w_quot   = r_negLo ? -r_mplr : r_mplr;
  assign w_remRaw = r_acc[WIDTH-1:0];
  assign w_rem    = r_negHi ? -w_remRaw : w_remRaw;
  assign resHi    = r_isDiv ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
  assign resLo    = r_isDiv ? w_quot : w_prod[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu
//  Description : Clocked EX-stage ALU. Single-cycle ops write Y/flags on the
//                accepting edge; mul/div run through malu_muldiv_core with a
//                start/busy/done handshake and report on HI/LO.
//                Option macro MALU_EARLY_OUT_EN (see malu_muldiv_core).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu
  import malu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic  clk,
  input  logic  reset,
  malu_if.slave bus
);

  state_e           r_state;
  state_e           w_stateNext;
  logic             w_accept;
  logic             w_coreLoad;
  logic             w_step;
  logic             w_lastIter;
  logic [WIDTH-1:0] w_coreHi;
  logic [WIDTH-1:0] w_coreLo;

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [3:0]       r_flags;
  logic             r_div0;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_yNew;
  logic             w_writeY;
  logic             w_cNew;
  logic             w_vNew;
  logic [3:0]       w_flagsNew;
  logic             w_bZero;

  assign w_bZero = (bus.B == '0);

  malu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (w_coreLoad),
    .loadDiv    (bus.operation == OP_DIV),
    .loadSigned (bus.sign[0]),
    .opA        (bus.A),
    .opB        (bus.B),
    .step       (w_step),
    .lastIter   (w_lastIter),
    .resHi      (w_coreHi),
    .resLo      (w_coreLo)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state plus accept/load/step strobes; start is only looked at in IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_coreLoad  = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.operation == OP_MUL) begin
            w_coreLoad  = 1'b1;
            w_stateNext = MUL;
          end else if (bus.operation == OP_DIV && !w_bZero) begin
            w_coreLoad  = 1'b1;
            w_stateNext = DIV;
          end
        end
      end
      MUL, DIV: begin
        w_step = 1'b1;
        if (w_lastIter) w_stateNext = FIX;
      end
      FIX:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Single-cycle datapath; add/sub derive carry/borrow and overflow for both sign modes.
  assign w_sum   = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff  = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_shamt = bus.A[SHW-1:0];

  always_comb begin
    w_yNew   = '0;
    w_writeY = 1'b1;
    w_cNew   = 1'b0;
    w_vNew   = 1'b0;
    case (bus.operation)
      OP_PASSB: w_yNew = bus.B;
      OP_ADDSUB: begin
        if (bus.sign[1]) begin
          w_yNew = w_diff[WIDTH-1:0];
          w_cNew = w_diff[WIDTH];
          w_vNew = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
        end else begin
          w_yNew = w_sum[WIDTH-1:0];
          w_cNew = w_sum[WIDTH];
          w_vNew = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
        end
      end
      OP_AND:  w_yNew = bus.A & bus.B;
      OP_OR:   w_yNew = bus.A | bus.B;
      OP_NOR:  w_yNew = ~(bus.A | bus.B);
      OP_SRL:  w_yNew = bus.B >> w_shamt;
      OP_SLL:  w_yNew = bus.B << w_shamt;
      OP_SRA:  w_yNew = $unsigned($signed(bus.B) >>> w_shamt);
      OP_LUI:  w_yNew = {bus.A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: w_writeY = 1'b0;   // mul, div and illegal codes leave Y alone
    endcase
    w_flagsNew        = '0;
    w_flagsNew[FLG_V] = w_vNew;
    w_flagsNew[FLG_N] = w_yNew[WIDTH-1];
    w_flagsNew[FLG_Z] = (w_yNew == '0);
    w_flagsNew[FLG_C] = w_cNew;
  end

  // Output registers: single-cycle results on acceptance, HI/LO when the core finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_flags <= '0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (bus.operation == OP_DIV) begin
          if (w_bZero) begin
            r_div0 <= 1'b1;
            r_hi   <= bus.A;
            r_lo   <= '1;
            r_done <= 1'b1;
          end else begin
            r_div0 <= 1'b0;
          end
        end else if (bus.operation != OP_MUL) begin
          r_done <= 1'b1;
          if (w_writeY) begin
            r_y     <= w_yNew;
            r_flags <= w_flagsNew;
          end
        end
      end
      if (r_state == FIX) begin
        r_hi   <= w_coreHi;
        r_lo   <= w_coreLo;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.Y         = r_y;
  assign bus.outHI     = r_hi;
  assign bus.outLO     = r_lo;
  assign bus.carryFlag = r_flags;
  assign bus.div0      = r_div0;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_alu
//  Description : Self-checking bench for multicycle_alu (WIDTH=32): directed
//                cases plus random operations against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

  logic clk = 1'b0;
  logic reset;
  int   nAssert = 0;
  int   nFail   = 0;

  // Expected architectural state held by the reference model.
  logic [31:0] eY, eHi, eLo;
  logic [3:0]  eFlags;
  logic        eDiv0;
  int          eLat;

  malu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    eY = '0; eHi = '0; eLo = '0; eFlags = '0; eDiv0 = 1'b0;
  endtask

  // Behavioural model: 64-bit integer arithmetic on the operand values.
  task automatic model(input logic [3:0] op, input logic [1:0] sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, sr, mag;
    logic [63:0] p;
    logic [31:0] y;
    logic wr, c, v;
    int sh, k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = int'(a[4:0]);
    wr = 1'b1; c = 1'b0; v = 1'b0; y = '0; eLat = 1;
    case (op)
      4'd0: y = b;
      4'd1: begin
        if (sg[1]) begin
          sr = ua - ub; p = sr; y = p[31:0]; c = (ua < ub);
          sr = sa - sb;
        end else begin
          sr = ua + ub; p = sr; y = p[31:0]; c = (sr > 64'sd4294967295);
          sr = sa + sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: begin
        wr = 1'b0;
        if (sg[0]) p = sa * sb; else p = ua * ub;
        eHi = p[63:32]; eLo = p[31:0];
`ifdef MALU_EARLY_OUT_EN
        mag = (sg[0] && b[31]) ? -sb : ub;
        k = 0;
        while (mag != 0) begin k++; mag = mag >> 1; end
        if (k == 0) k = 1;
        eLat = k + 2;
`else
        eLat = 34;
`endif
      end
      4'd3: begin
        wr = 1'b0;
        if (b == 32'h0) begin
          eDiv0 = 1'b1; eHi = a; eLo = 32'hFFFF_FFFF;
        end else begin
          eDiv0 = 1'b0; eLat = 34;
          if (sg[0]) begin p = sa / sb; eLo = p[31:0]; p = sa % sb; eHi = p[31:0]; end
          else       begin p = ua / ub; eLo = p[31:0]; p = ua % ub; eHi = p[31:0]; end
        end
      end
      4'd4:  y = a & b;
      4'd5:  y = a | b;
      4'd6:  y = ~(a | b);
      4'd7:  begin sr = ub >> sh; p = sr; y = p[31:0]; end
      4'd8:  begin sr = ub << sh; p = sr; y = p[31:0]; end
      4'd9:  begin sr = sb >>> sh; p = sr; y = p[31:0]; end
      4'd10: y = {a[15:0], 16'h0};
      default: wr = 1'b0;
    endcase
    if (wr) begin
      eY = y;
      eFlags = {c, (y == 32'h0), y[31], v};
    end
  endtask

  // Issue one operation, measure latency and busy time, then check all outputs.
  task automatic runOp(input logic [3:0] op, input logic [1:0] sg, input logic [31:0] a,
                       input logic [31:0] b, input int pokeAt);
    int lat, busyCnt;
    @(negedge clk);
    bus.start = 1'b1; bus.operation = op; bus.sign = sg; bus.A = a; bus.B = b;
    model(op, sg, a, b);
    @(posedge clk);
    lat = 1; busyCnt = 0;
    #1;
    bus.start = 1'b0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busyCnt++;
      bus.A = $urandom; bus.B = $urandom; bus.sign = 2'($urandom_range(0, 3));
      if (lat == pokeAt) begin
        bus.start = 1'b1; bus.operation = 4'b0100;
      end else begin
        bus.start = 1'b0; bus.operation = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      lat++;
      #1;
    end
    bus.start = 1'b0;
    chk("latency", lat, eLat);
    chk("busyCycles", busyCnt, eLat - 1);
    chk("Y", bus.Y, eY);
    chk("flags", bus.carryFlag, eFlags);
    chk("outHI", bus.outHI, eHi);
    chk("outLO", bus.outLO, eLo);
    chk("div0", bus.div0, eDiv0);
    @(posedge clk);
    #1;
    chk("donePulse", bus.done, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          sawDone;
    reset = 1'b1;
    bus.start = 1'b0; bus.operation = '0; bus.sign = '0; bus.A = '0; bus.B = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Y", bus.Y, 32'h0);
    chk("rst_HI", bus.outHI, 32'h0);
    chk("rst_LO", bus.outLO, 32'h0);
    chk("rst_flags", bus.carryFlag, 4'h0);
    chk("rst_busyDoneDiv0", {bus.busy, bus.done, bus.div0}, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Add overflow and subtract borrow.
    runOp(4'b0001, 2'b01, 32'h7FFF_FFFF, 32'h1, -1);
    chk("add_Y", bus.Y, 32'h8000_0000);
    chk("add_flags", bus.carryFlag, 4'b0011);
    runOp(4'b0001, 2'b10, 32'h0, 32'h1, -1);
    chk("sub_Y", bus.Y, 32'hFFFF_FFFF);
    chk("sub_flags", bus.carryFlag, 4'b1010);

    // Signed multiply and divide, divide by zero, MIN / -1.
    runOp(4'b0010, 2'b01, 32'hFFFF_FFFD, 32'h7, -1);
    chk("mul_HI", bus.outHI, 32'hFFFF_FFFF);
    chk("mul_LO", bus.outLO, 32'hFFFF_FFEB);
    runOp(4'b0011, 2'b01, 32'hFFFF_FFF9, 32'h2, -1);
    chk("div_LO", bus.outLO, 32'hFFFF_FFFD);
    chk("div_HI", bus.outHI, 32'hFFFF_FFFF);
    runOp(4'b0011, 2'b01, 32'h5, 32'h0, -1);
    chk("div0_flag", bus.div0, 1'b1);
    chk("div0_HI", bus.outHI, 32'h5);
    chk("div0_LO", bus.outLO, 32'hFFFF_FFFF);
    runOp(4'b0011, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("minDiv_LO", bus.outLO, 32'h8000_0000);
    chk("minDiv_HI", bus.outHI, 32'h0);

    // Shifts use only the low 5 bits of A.
    runOp(4'b1001, 2'b00, 32'd4, 32'h8000_0000, -1);
    chk("sra_Y", bus.Y, 32'hF800_0000);
    runOp(4'b1001, 2'b00, 32'd36, 32'h8000_0000, -1);
    chk("sra36_Y", bus.Y, 32'hF800_0000);
    runOp(4'b1000, 2'b00, 32'd31, 32'h1, -1);
    chk("sll_Y", bus.Y, 32'h8000_0000);
    chk("sll_N", bus.carryFlag[1], 1'b1);

    // Illegal code holds results; start during busy is ignored.
    runOp(4'b1101, 2'b00, 32'h1234, 32'h5678, -1);
    runOp(4'b0010, 2'b00, 32'h0001_0003, 32'h0000_0105, 5);

    // Unsigned multiply by one (early-out case when enabled).
    runOp(4'b0010, 2'b00, 32'h3, 32'h1, -1);
    chk("mul1_HI", bus.outHI, 32'h0);
    chk("mul1_LO", bus.outLO, 32'h3);
`ifdef MALU_EARLY_OUT_EN
    chk("mul1_lat", eLat, 3);
`else
    chk("mul1_lat", eLat, 34);
`endif

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'b0010; bus.sign = 2'b00; bus.A = 32'hFFFF; bus.B = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    modelReset();
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_HI", bus.outHI, 32'h0);
    chk("abort_LO", bus.outLO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) sawDone = 1'b1;
    end
    chk("abort_noDone", sawDone, 1'b0);

    // Random operations, biased toward mul/div and corner operands.
    for (int n = 0; n < 220; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(2, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'h1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(0, 255));
        default: b = $urandom;
      endcase
      runOp(op, 2'($urandom_range(0, 3)), a, b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire
